fpu_result_wb: RTL and testbench
================================

Name: fpu_result_wb

Overview:
- Write-back responder for the FPU datapath; the producer side of the completion interface that the decode stage consumes.
- Accepts completed operations from the FPU execution units and buffers them in a small FIFO.
- Retires one completion per cycle toward decode/GPR write-back. A retire drives the `fpu_complete` / `fpu_complete_rd` pulses, the result buses, the destination register and the per-op exception flags (`S_flag`).
- Applies back-pressure to the execution units when the buffer is full.

Parameters:
- DEPTH, 2, FIFO entries; power of two, minimum 2.
- AW, 1, FIFO pointer width; equals log2(DEPTH).

Ports:
- clk  input  1  clock; all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- ex_valid  input  1  execution unit presents a completed op this cycle.
- ex_ready  output  1  block can accept `ex_valid` this cycle.
- ex_result  input  32  op result (IEEE-754 single or integer).
- ex_flags  input  5  exception flags {NV,DZ,OF,UF,NX}.
- ex_rd  input  5  destination register index.
- ex_int_dest  input  1  1 = destination is integer GPR (compare, class, fcvt.w, fmv.x.w); 0 = float register.
- wb_stall  input  1  decode write port busy (e.g. CSR read-back); hold retirement.
- fpu_complete  output  1  one-cycle pulse per retired op.
- fpu_complete_rd  output  1  one-cycle pulse; retired op writes the integer GPR.
- fpu_result_rd_w  output  32  integer write-back data; valid while `fpu_complete_rd`=1.
- fpu_result_1  output  32  float result; valid while `fpu_complete`=1 and `ex_int_dest` was 0.
- wb_rd  output  5  destination of the retired op.
- S_flag  output  5  flags of the retired op; valid with `fpu_complete`.
- ovf_err  output  1  sticky; set when `ex_valid`=1 while `ex_ready`=0.

Behaviour:
- Reset (`rst`=1 at clock edge):
  - FIFO emptied; pointers and count cleared.
  - All outputs cleared to 0.
  - `ex_ready` = 1 from the first cycle after reset.
  - Any in-flight entries are discarded.
  - Reset dominates all simultaneous events.
- `ex_ready` is combinational: count < DEPTH. Accept occurs on a cycle with `ex_valid` & `ex_ready`.
- Retire decision in cycle N: a candidate exists and `wb_stall`=0.
  - Candidate is the FIFO head if count > 0.
  - Otherwise the candidate is the accepted input (bypass path).
- Retire outputs:
  - All output registers load at the end of cycle N and are valid in cycle N+1 only.
  - Next cycle they return to 0 unless another retire occurs; back-to-back retires give continuous pulses.
- Latency: empty FIFO, no stall: `ex_valid` in cycle N → `fpu_complete` in cycle N+1. Throughput is 1 op/cycle.
- When not retiring: an accepted input is pushed to the FIFO tail, and `wb_stall` holds the head unchanged.
- Simultaneous push and pop:
  - Non-empty FIFO: head pops, input pushes, count unchanged.
  - Order is strictly FIFO; bypass only when count = 0.
- Full FIFO:
  - With `wb_stall`=0 a pop occurs, but `ex_ready` stays 0 that cycle because it is count-based, not pop-aware.
  - A push while full is dropped, sets `ovf_err`, and does not corrupt the FIFO.
- Destination handling:
  - `fpu_complete_rd` = `ex_int_dest` & (`ex_rd` != 0).
  - Integer op with rd = x0: `fpu_complete` pulses, `fpu_complete_rd` stays 0, `fpu_result_rd_w` = 0.
  - Float op: `fpu_result_1` = result, `fpu_result_rd_w` = 0.
  - Integer op: `fpu_result_rd_w` = result, `fpu_result_1` = 0.
- Pointer wrap: modulo DEPTH.
- `ovf_err` clears only on `rst`.

Optional Feature:
- Macro FPU_WB_FLAG_ACCRUE_EN.
- When defined:
  - Adds input `fflags_clr` (1) and output `fflags_acc` (5).
  - `fflags_acc` ORs `S_flag` of every retired op and updates in the same cycle `S_flag` is valid.
  - `fflags_clr`=1 zeroes it next cycle; a retire in the same cycle as clear loads only that op's flags.
  - Reset value is 0.
- When undefined: neither port exists and there is no accrual logic.

Test Plan:
- Reset then single float op: `ex_result`=32'h3F800000, flags=5'b00001, rd=3 → next cycle `fpu_complete`=1, `fpu_result_1`=32'h3F800000, `S_flag`=5'b00001, `wb_rd`=3, `fpu_complete_rd`=0; all outputs 0 the following cycle.
- Integer op: rd=5, `ex_int_dest`=1, result=32'h00000001 → `fpu_complete_rd`=1, `fpu_result_rd_w`=1. Same op with rd=0 → `fpu_complete`=1, `fpu_complete_rd`=0.
- `wb_stall` held 3 cycles while ops A, B are pushed (DEPTH=2) → `ex_ready`=0 after two pushes. Release stall → A then B retire on consecutive cycles, in order.
- Push while full (stall held) → `ovf_err`=1 and stays 1; FIFO still retires only A, B.
- `rst` asserted with 2 entries buffered and stall active → next cycle count=0, `ex_ready`=1, no `fpu_complete` after stall release.
- With FPU_WB_FLAG_ACCRUE_EN: retire flags 5'b00001 then 5'b10000 → `fflags_acc`=5'b10001. Pulse `fflags_clr` → 5'b00000. Clear concurrent with retire of 5'b00100 → 5'b00100.

Source files
------------

// File: rtl/fpu_result_wb.sv
`default_nettype none
// ============================================================================
// Module   : fpu_result_wb
// Brief    : FPU write-back responder. Buffers completed ops in a small FIFO
//            and retires one per cycle toward decode / GPR write-back.
//            Optional flag accrual is enabled by FPU_WB_FLAG_ACCRUE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module fpu_result_wb #(
  parameter int DEPTH = 2,
  parameter int AW    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [31:0] ex_result,
  input  logic [4:0]  ex_flags,
  input  logic [4:0]  ex_rd,
  input  logic        ex_int_dest,
  input  logic        wb_stall,
  output logic        fpu_complete,
  output logic        fpu_complete_rd,
  output logic [31:0] fpu_result_rd_w,
  output logic [31:0] fpu_result_1,
  output logic [4:0]  wb_rd,
  output logic [4:0]  S_flag,
  output logic        ovf_err
`ifdef FPU_WB_FLAG_ACCRUE_EN
  ,
  input  logic        fflags_clr,
  output logic [4:0]  fflags_acc
`endif
);

  localparam int            c_EW    = 43;
  localparam logic [AW:0]   c_FULL  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   c_EMPTY = '0;

  // Entry layout: {int_dest, rd, flags, result}
  logic [c_EW-1:0] r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_count;

  logic            r_complete;
  logic            r_complete_rd;
  logic [31:0]     r_result_rd_w;
  logic [31:0]     r_result_1;
  logic [4:0]      r_wb_rd;
  logic [4:0]      r_s_flag;
  logic            r_ovf_err;

  logic            w_ready;
  logic            w_accept;
  logic            w_fifo_nonempty;
  logic            w_retire;
  logic            w_pop;
  logic            w_push;
  logic [c_EW-1:0] w_in_entry;
  logic [c_EW-1:0] w_cand;
  logic [31:0]     w_cand_result;
  logic [4:0]      w_cand_flags;
  logic [4:0]      w_cand_rd;
  logic            w_cand_int;
  logic            w_cand_wr_gpr;

  assign w_ready         = (r_count < c_FULL);
  assign w_accept        = ex_valid & w_ready;
  assign w_fifo_nonempty = (r_count != c_EMPTY);
  assign w_in_entry      = {ex_int_dest, ex_rd, ex_flags, ex_result};

  // Bypass the FIFO only when it is empty so ordering stays strict.
  assign w_cand   = w_fifo_nonempty ? r_mem[r_rd_ptr] : w_in_entry;
  assign w_retire = (w_fifo_nonempty | w_accept) & ~wb_stall;
  assign w_pop    = w_retire & w_fifo_nonempty;
  assign w_push   = w_accept & ~(w_retire & ~w_fifo_nonempty);

  assign w_cand_result = w_cand[31:0];
  assign w_cand_flags  = w_cand[36:32];
  assign w_cand_rd     = w_cand[41:37];
  assign w_cand_int    = w_cand[42];
  assign w_cand_wr_gpr = w_cand_int & (w_cand_rd != 5'd0);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_in_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

  // Retire outputs are single-cycle: they clear unless another retire follows.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_complete    <= 1'b0;
      r_complete_rd <= 1'b0;
      r_result_rd_w <= '0;
      r_result_1    <= '0;
      r_wb_rd       <= '0;
      r_s_flag      <= '0;
      r_ovf_err     <= 1'b0;
    end else begin
      r_complete    <= w_retire;
      r_complete_rd <= w_retire & w_cand_wr_gpr;
      r_result_rd_w <= (w_retire & w_cand_wr_gpr) ? w_cand_result : 32'd0;
      r_result_1    <= (w_retire & ~w_cand_int) ? w_cand_result : 32'd0;
      r_wb_rd       <= w_retire ? w_cand_rd : 5'd0;
      r_s_flag      <= w_retire ? w_cand_flags : 5'd0;
      if (ex_valid & ~w_ready) begin
        r_ovf_err <= 1'b1;
      end
    end
  end

`ifdef FPU_WB_FLAG_ACCRUE_EN
  logic [4:0] r_fflags_acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fflags_acc <= '0;
    end else begin
      r_fflags_acc <= (fflags_clr ? 5'd0 : r_fflags_acc) |
                      (w_retire ? w_cand_flags : 5'd0);
    end
  end

  assign fflags_acc = r_fflags_acc;
`endif

  assign ex_ready        = w_ready;
  assign fpu_complete    = r_complete;
  assign fpu_complete_rd = r_complete_rd;
  assign fpu_result_rd_w = r_result_rd_w;
  assign fpu_result_1    = r_result_1;
  assign wb_rd           = r_wb_rd;
  assign S_flag          = r_s_flag;
  assign ovf_err         = r_ovf_err;

endmodule
`default_nettype wire

// File: tb/tb_fpu_result_wb.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpu_result_wb
// Brief    : Self-checking bench for fpu_result_wb: queue-based reference
//            model compared every cycle plus directed literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fpu_result_wb;

  localparam int DEPTH = 2;
  localparam int AW    = 1;

  logic        clk;
  logic        rst;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_result;
  logic [4:0]  ex_flags;
  logic [4:0]  ex_rd;
  logic        ex_int_dest;
  logic        wb_stall;
  logic        fpu_complete;
  logic        fpu_complete_rd;
  logic [31:0] fpu_result_rd_w;
  logic [31:0] fpu_result_1;
  logic [4:0]  wb_rd;
  logic [4:0]  S_flag;
  logic        ovf_err;
  logic        fflags_clr;
  logic [4:0]  fflags_acc;

  int n_tests;
  int n_fail;

  fpu_result_wb #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk             (clk),
    .rst             (rst),
    .ex_valid        (ex_valid),
    .ex_ready        (ex_ready),
    .ex_result       (ex_result),
    .ex_flags        (ex_flags),
    .ex_rd           (ex_rd),
    .ex_int_dest     (ex_int_dest),
    .wb_stall        (wb_stall),
    .fpu_complete    (fpu_complete),
    .fpu_complete_rd (fpu_complete_rd),
    .fpu_result_rd_w (fpu_result_rd_w),
    .fpu_result_1    (fpu_result_1),
    .wb_rd           (wb_rd),
    .S_flag          (S_flag),
    .ovf_err         (ovf_err)
`ifdef FPU_WB_FLAG_ACCRUE_EN
    ,
    .fflags_clr      (fflags_clr),
    .fflags_acc      (fflags_acc)
`endif
  );

`ifndef FPU_WB_FLAG_ACCRUE_EN
  assign fflags_acc = 5'd0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic        intd;
    logic [4:0]  rd;
    logic [4:0]  flags;
    logic [31:0] res;
  } op_t;

  op_t         mq[$];
  bit          m_live = 0;
  logic        e_complete, e_crd, e_ovf;
  logic [31:0] e_rdw, e_r1;
  logic [4:0]  e_wbrd, e_sf, e_acc;

  always @(posedge clk) begin
    op_t in_op;
    op_t cand;
    bit  ready, acc_in, was_empty, ret;
    if (rst) begin
      mq.delete();
      {e_complete, e_crd, e_ovf} = '0;
      e_rdw = '0; e_r1 = '0; e_wbrd = '0; e_sf = '0; e_acc = '0;
      m_live = 1;
    end else begin
      in_op     = '{intd: ex_int_dest, rd: ex_rd, flags: ex_flags, res: ex_result};
      ready     = mq.size() < DEPTH;
      acc_in    = ex_valid && ready;
      was_empty = (mq.size() == 0);
      if (ex_valid && !ready) e_ovf = 1'b1;
      cand = was_empty ? in_op : mq[0];
      ret  = (!was_empty || acc_in) && !wb_stall;
      e_complete = ret;
      e_crd  = ret && cand.intd && (cand.rd != 5'd0);
      e_rdw  = e_crd ? cand.res : 32'd0;
      e_r1   = (ret && !cand.intd) ? cand.res : 32'd0;
      e_wbrd = ret ? cand.rd : 5'd0;
      e_sf   = ret ? cand.flags : 5'd0;
      e_acc  = (fflags_clr ? 5'd0 : e_acc) | e_sf;
      if (ret && !was_empty) void'(mq.pop_front());
      if (acc_in && !(ret && was_empty)) mq.push_back(in_op);
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("m_ready",    32'(ex_ready),        32'(mq.size() < DEPTH));
      chk("m_complete", 32'(fpu_complete),    32'(e_complete));
      chk("m_crd",      32'(fpu_complete_rd), 32'(e_crd));
      chk("m_rdw",      fpu_result_rd_w,      e_rdw);
      chk("m_r1",       fpu_result_1,         e_r1);
      chk("m_wbrd",     32'(wb_rd),           32'(e_wbrd));
      chk("m_sflag",    32'(S_flag),          32'(e_sf));
      chk("m_ovf",      32'(ovf_err),         32'(e_ovf));
`ifdef FPU_WB_FLAG_ACCRUE_EN
      chk("m_acc",      32'(fflags_acc),      32'(e_acc));
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic v, input logic [31:0] res, input logic [4:0] fl,
                       input logic [4:0] rd, input logic intd, input logic stall);
    ex_valid = v; ex_result = res; ex_flags = fl; ex_rd = rd;
    ex_int_dest = intd; wb_stall = stall;
    @(posedge clk); #1;
  endtask

  task automatic idle(input logic stall);
    drive(1'b0, 32'd0, 5'd0, 5'd0, 1'b0, stall);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(1'b0);
    idle(1'b0);
    rst = 1'b0;
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    rst = 1'b1; fflags_clr = 1'b0;
    ex_valid = 0; ex_result = 0; ex_flags = 0; ex_rd = 0; ex_int_dest = 0; wb_stall = 0;
    do_reset();
    chk("rst_ready",    32'(ex_ready), 32'd1);
    chk("rst_complete", 32'(fpu_complete), 32'd0);
    chk("rst_ovf",      32'(ovf_err), 32'd0);

    // single float op
    drive(1'b1, 32'h3F800000, 5'b00001, 5'd3, 1'b0, 1'b0);
    chk("f_complete", 32'(fpu_complete), 32'd1);
    chk("f_result1",  fpu_result_1, 32'h3F800000);
    chk("f_sflag",    32'(S_flag), 32'h01);
    chk("f_wbrd",     32'(wb_rd), 32'd3);
    chk("f_crd",      32'(fpu_complete_rd), 32'd0);
    chk("f_rdw",      fpu_result_rd_w, 32'd0);
    idle(1'b0);
    chk("f_clear_complete", 32'(fpu_complete), 32'd0);
    chk("f_clear_result1",  fpu_result_1, 32'd0);
    chk("f_clear_sflag",    32'(S_flag), 32'd0);

    // integer ops, rd=5 then rd=x0
    drive(1'b1, 32'h00000001, 5'b00000, 5'd5, 1'b1, 1'b0);
    chk("i_crd",     32'(fpu_complete_rd), 32'd1);
    chk("i_rdw",     fpu_result_rd_w, 32'd1);
    chk("i_result1", fpu_result_1, 32'd0);
    drive(1'b1, 32'h00000001, 5'b00000, 5'd0, 1'b1, 1'b0);
    chk("x0_complete", 32'(fpu_complete), 32'd1);
    chk("x0_crd",      32'(fpu_complete_rd), 32'd0);
    chk("x0_rdw",      fpu_result_rd_w, 32'd0);

    // stall: push A, B, then overflow push C
    drive(1'b1, 32'hAAAA0001, 5'b00010, 5'd7, 1'b0, 1'b1);
    drive(1'b1, 32'hBBBB0002, 5'b00100, 5'd8, 1'b0, 1'b1);
    chk("full_ready", 32'(ex_ready), 32'd0);
    chk("stall_complete", 32'(fpu_complete), 32'd0);
    drive(1'b1, 32'hCCCC0003, 5'b01000, 5'd9, 1'b0, 1'b1);
    chk("ovf_set", 32'(ovf_err), 32'd1);
    idle(1'b0);
    chk("A_result", fpu_result_1, 32'hAAAA0001);
    chk("A_wbrd",   32'(wb_rd), 32'd7);
    idle(1'b0);
    chk("B_result", fpu_result_1, 32'hBBBB0002);
    chk("B_wbrd",   32'(wb_rd), 32'd8);
    idle(1'b0);
    chk("noC_complete", 32'(fpu_complete), 32'd0);
    chk("ovf_sticky",   32'(ovf_err), 32'd1);

    // reset with two entries buffered and stall active
    drive(1'b1, 32'h11110000, 5'd0, 5'd1, 1'b0, 1'b1);
    drive(1'b1, 32'h22220000, 5'd0, 5'd2, 1'b0, 1'b1);
    rst = 1'b1;
    idle(1'b1);
    rst = 1'b0;
    chk("rst2_ready", 32'(ex_ready), 32'd1);
    chk("rst2_ovf",   32'(ovf_err), 32'd0);
    idle(1'b0);
    chk("rst2_nocomp1", 32'(fpu_complete), 32'd0);
    idle(1'b0);
    chk("rst2_nocomp2", 32'(fpu_complete), 32'd0);

    // full FIFO with stall released while pushing: pop occurs, push dropped
    drive(1'b1, 32'h0000D001, 5'd1, 5'd4, 1'b0, 1'b1);
    drive(1'b1, 32'h0000D002, 5'd2, 5'd4, 1'b0, 1'b1);
    drive(1'b1, 32'h0000D003, 5'd3, 5'd4, 1'b0, 1'b0);
    chk("fullpop_result", fpu_result_1, 32'h0000D001);
    chk("fullpop_ovf",    32'(ovf_err), 32'd1);
    drive(1'b1, 32'h0000D004, 5'd4, 5'd4, 1'b0, 1'b0);
    chk("pushpop_result", fpu_result_1, 32'h0000D002);
    idle(1'b0);
    chk("pushpop_tail", fpu_result_1, 32'h0000D004);
    idle(1'b0);

`ifdef FPU_WB_FLAG_ACCRUE_EN
    do_reset();
    drive(1'b1, 32'h1, 5'b00001, 5'd3, 1'b0, 1'b0);
    drive(1'b1, 32'h2, 5'b10000, 5'd3, 1'b0, 1'b0);
    chk("acc_or", 32'(fflags_acc), 32'h11);
    fflags_clr = 1'b1;
    idle(1'b0);
    chk("acc_clr", 32'(fflags_acc), 32'h00);
    drive(1'b1, 32'h3, 5'b00010, 5'd3, 1'b0, 1'b0);
    fflags_clr = 1'b1;
    drive(1'b1, 32'h4, 5'b00100, 5'd3, 1'b0, 1'b0);
    chk("acc_clr_retire", 32'(fflags_acc), 32'h04);
    fflags_clr = 1'b0;
    idle(1'b0);
`endif

    // mixed traffic checked cycle-by-cycle against the model
    do_reset();
    for (int i = 0; i < 300; i++) begin
      fflags_clr = ($urandom_range(0, 7) == 0);
      drive(1'($urandom_range(0, 3) != 0), $urandom, 5'($urandom), 5'($urandom_range(0, 3)),
            1'($urandom), 1'($urandom_range(0, 2) == 0));
    end
    fflags_clr = 1'b0;
    idle(1'b0);
    idle(1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
